// File: rtl/thread_fetch_unit.sv
// Instruction-fetch stage for the barrel-threaded RV32 core: one PC per hardware thread,
// round-robin thread pick, and an IF/ID register handshaking with decode.
module thread_fetch_unit #(
    parameter int               XLEN         = 32,
    parameter int               INSTR_WIDTH  = 32,
    parameter int               THREAD_WIDTH = 3,
    parameter int               NUM_THREADS  = 2**THREAD_WIDTH,
    parameter logic [XLEN-1:0]  RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_THREADS-1:0]  thread_en,
    output logic [XLEN-1:0]         imem_pc,
    output logic [THREAD_WIDTH-1:0] imem_thread_id,
    input  logic [INSTR_WIDTH-1:0]  imem_instr,
    input  logic                    redirect_valid,
    input  logic [THREAD_WIDTH-1:0] redirect_thread,
    input  logic [XLEN-1:0]         redirect_pc,
    input  logic                    id_ready,
    output logic                    if_valid,
    output logic [XLEN-1:0]         if_pc,
    output logic [THREAD_WIDTH-1:0] if_thread_id,
    output logic [INSTR_WIDTH-1:0]  if_instr
);

    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

    logic [XLEN-1:0]         pc_q [NUM_THREADS];
    logic [THREAD_WIDTH-1:0] cur_q;
    logic [THREAD_WIDTH-1:0] sel;
    logic [THREAD_WIDTH-1:0] cand;
    logic                    found;
    logic                    any_en;
    logic                    redirect_hits_sel;
    logic                    squash;
    logic                    issue;
    logic [XLEN-1:0]         redirect_aligned;
    logic [1:0]              unused_redirect_bits;

    assign unused_redirect_bits = redirect_pc[1:0];
    assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};

    // Scan from the pointer forward; when nothing is enabled the pointer itself is presented.
    always_comb begin
        sel   = cur_q;
        cand  = cur_q;
        found = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cand = cur_q + THREAD_WIDTH'(i);
            if (!found && thread_en[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign any_en         = |thread_en;
    assign imem_pc        = pc_q[sel];
    assign imem_thread_id = sel;

    assign redirect_hits_sel = redirect_valid && (redirect_thread == sel);
    assign issue  = any_en && (!if_valid || id_ready) && !redirect_hits_sel;
    assign squash = if_valid && redirect_valid && (redirect_thread == if_thread_id);

    // A redirect overrides the increment of the same thread.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (rst) begin
                pc_q[t] <= RESET_PC;
            end else if (redirect_valid && (redirect_thread == THREAD_WIDTH'(t))) begin
                pc_q[t] <= redirect_aligned;
            end else if (issue && (sel == THREAD_WIDTH'(t))) begin
                pc_q[t] <= pc_q[t] + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q        <= '0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_thread_id <= '0;
            if_instr     <= NOP;
        end else if (issue) begin
            cur_q        <= sel + THREAD_WIDTH'(1);
            if_valid     <= 1'b1;
            if_pc        <= pc_q[sel];
            if_thread_id <= sel;
            if_instr     <= imem_instr;
        end else if (id_ready || squash) begin
            if_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Directed bench for thread_fetch_unit: round-robin order, sparse enables, stalls,
// redirects with squash, disable/re-enable, PC wrap and reset during a stall.
module tb_thread_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  thread_en;
    logic [31:0] imem_pc;
    logic [2:0]  imem_thread_id;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [2:0]  redirect_thread;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [2:0]  if_thread_id;
    logic [31:0] if_instr;

    int n_checks = 0;
    int n_fail   = 0;

    thread_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .thread_en       (thread_en),
        .imem_pc         (imem_pc),
        .imem_thread_id  (imem_thread_id),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_thread (redirect_thread),
        .redirect_pc     (redirect_pc),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_thread_id    (if_thread_id),
        .if_instr        (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory stub: word is a tagged function of thread and address.
    function automatic logic [31:0] imem_word(input logic [2:0] t, input logic [31:0] pc);
        return {1'b1, t, pc[27:0]};
    endfunction

    assign imem_instr = imem_word(imem_thread_id, imem_pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        thread_en = 8'hFF;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_thread = 3'd0;
        redirect_pc = 32'h0;
        tick();
        tick();
        n_checks++;
        if ({if_valid, if_thread_id, if_pc, if_instr} !== {1'b0, 3'd0, 32'h0, 32'h0000_0013}) begin
            n_fail++;
            $display("[TB] FAIL reset_if: got v=%0b t=%0d pc=%h instr=%h, expected v=0 t=0 pc=0 instr=00000013",
                     if_valid, if_thread_id, if_pc, if_instr);
        end
        n_checks++;
        if ({imem_thread_id, imem_pc} !== {3'd0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_imem: got t=%0d pc=%h, expected t=0 pc=0", imem_thread_id, imem_pc);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  et;
        logic [31:0] ep;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            et = 3'(k % 8);
            ep = 32'((k / 8) * 4);
            n_checks++;
            if ({if_valid, if_thread_id, if_pc, if_instr} !== {1'b1, et, ep, imem_word(et, ep)}) begin
                n_fail++;
                $display("[TB] FAIL rr_seq[%0d]: got v=%0b t=%0d pc=%h instr=%h, expected v=1 t=%0d pc=%h instr=%h",
                         k, if_valid, if_thread_id, if_pc, if_instr, et, ep, imem_word(et, ep));
            end
        end
    endtask

    task automatic test_sparse_enable();
        logic [2:0]  exp_t  [5] = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd0};
        logic [31:0] exp_pc [5] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        logic [31:0] probe_pc;
        thread_en = 8'h05;
        id_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_thread_id, if_pc, if_instr} !==
                {1'b1, exp_t[k], exp_pc[k], imem_word(exp_t[k], exp_pc[k])}) begin
                n_fail++;
                $display("[TB] FAIL sparse_seq[%0d]: got v=%0b t=%0d pc=%h, expected v=1 t=%0d pc=%h",
                         k, if_valid, if_thread_id, if_pc, exp_t[k], exp_pc[k]);
            end
        end
        // Hold decode so probing thread_en cannot issue; read every thread's PC through imem.
        id_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            thread_en = 8'(1 << i);
            #1;
            probe_pc = (i == 0) ? 32'hC : (i == 2) ? 32'h8 : 32'h0;
            n_checks++;
            if ({imem_thread_id, imem_pc} !== {3'(i), probe_pc}) begin
                n_fail++;
                $display("[TB] FAIL sparse_pc[%0d]: got t=%0d pc=%h, expected t=%0d pc=%h",
                         i, imem_thread_id, imem_pc, i, probe_pc);
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_t [3] = '{3'd3, 3'd4, 3'd5};
        thread_en = 8'hFF;
        id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_thread_id, if_pc, if_instr, imem_thread_id, imem_pc} !==
                {1'b1, 3'd2, 32'h0, imem_word(3'd2, 32'h0), 3'd3, 32'h0}) begin
                n_fail++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%0b t=%0d pc=%h sel=%0d imem_pc=%h, expected v=1 t=2 pc=0 sel=3 imem_pc=0",
                         k, if_valid, if_thread_id, if_pc, imem_thread_id, imem_pc);
            end
        end
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_thread_id, if_pc} !== {1'b1, exp_t[k], 32'h0}) begin
                n_fail++;
                $display("[TB] FAIL stall_resume[%0d]: got v=%0b t=%0d pc=%h, expected v=1 t=%0d pc=0",
                         k, if_valid, if_thread_id, if_pc, exp_t[k]);
            end
        end
    endtask

    task automatic test_redirect();
        logic [2:0]  exp_t  [8] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
        logic [31:0] exp_pc [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h104, 32'h200};
        thread_en = 8'hFF;
        id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_thread = 3'd2;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL redir_bubble: got v=%0b, expected v=0", if_valid);
        end
        tick();
        n_checks++;
        if ({if_valid, if_thread_id, if_pc, if_instr} !== {1'b1, 3'd2, 32'h100, imem_word(3'd2, 32'h100)}) begin
            n_fail++;
            $display("[TB] FAIL redir_target: got v=%0b t=%0d pc=%h, expected v=1 t=2 pc=00000100",
                     if_valid, if_thread_id, if_pc);
        end
        tick();
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_thread = 3'd3;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL redir_squash: got v=%0b, expected v=0", if_valid);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_thread_id, if_pc} !== {1'b1, exp_t[k], exp_pc[k]}) begin
                n_fail++;
                $display("[TB] FAIL redir_after[%0d]: got v=%0b t=%0d pc=%h, expected v=1 t=%0d pc=%h",
                         k, if_valid, if_thread_id, if_pc, exp_t[k], exp_pc[k]);
            end
        end
    endtask

    task automatic test_disable();
        thread_en = 8'hFF;
        id_ready = 1'b1;
        do_reset();
        tick();
        thread_en = 8'h00;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({if_valid, imem_thread_id, imem_pc} !== {1'b0, 3'd1, 32'h0}) begin
                n_fail++;
                $display("[TB] FAIL disable_idle[%0d]: got v=%0b sel=%0d imem_pc=%h, expected v=0 sel=1 imem_pc=0",
                         k, if_valid, imem_thread_id, imem_pc);
            end
        end
        thread_en = 8'h20;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_thread_id, if_pc} !== {1'b1, 3'd5, 32'(k * 4)}) begin
                n_fail++;
                $display("[TB] FAIL only_t5[%0d]: got v=%0b t=%0d pc=%h, expected v=1 t=5 pc=%h",
                         k, if_valid, if_thread_id, if_pc, 32'(k * 4));
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] exp_pc [3] = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        thread_en = 8'h01;
        id_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_thread = 3'd0;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_thread_id, if_pc, if_instr} !== {1'b1, 3'd0, exp_pc[k], imem_word(3'd0, exp_pc[k])}) begin
                n_fail++;
                $display("[TB] FAIL wrap[%0d]: got v=%0b t=%0d pc=%h, expected v=1 t=0 pc=%h",
                         k, if_valid, if_thread_id, if_pc, exp_pc[k]);
            end
        end
        id_ready = 1'b0;
        tick();
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_thread = 3'd0;
        redirect_pc = 32'h40;
        tick();
        n_checks++;
        if ({if_valid, if_thread_id, if_pc, if_instr, imem_thread_id, imem_pc} !==
            {1'b0, 3'd0, 32'h0, 32'h0000_0013, 3'd0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL stall_reset: got v=%0b t=%0d pc=%h instr=%h imem_pc=%h, expected v=0 t=0 pc=0 instr=00000013 imem_pc=0",
                     if_valid, if_thread_id, if_pc, if_instr, imem_pc);
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        tick();
        n_checks++;
        if ({if_valid, if_thread_id, if_pc} !== {1'b1, 3'd0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_fetch: got v=%0b t=%0d pc=%h, expected v=1 t=0 pc=0",
                     if_valid, if_thread_id, if_pc);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse_enable();
        test_stall();
        test_redirect();
        test_disable();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
